// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: two-requester round-robin front end for a single shared alu.
// A command is accepted from one requester, issued to the alu, and the alu
// result is captured. The result is then returned on a response channel
// tagged with the owning requester. Only one command is in flight at a time.
module alu_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  // command side
  input  logic [1:0]         REQ_VALID,
  output logic [1:0]         REQ_READY,
  input  logic [7:0]         REQ_OPCODE,
  input  logic [2*WIDTH-1:0] REQ_A,
  input  logic [2*WIDTH-1:0] REQ_B,
  // response side
  output logic               RSP_VALID,
  input  logic               RSP_READY,
  output logic               RSP_ID,
  output logic [WIDTH-1:0]   RSP_DATA,
  output logic [3:0]         RSP_FLAGS,
  output logic               BUSY,
  // alu pins
  output logic               ALU_EN,
  output logic               ALU_OE,
  output logic [3:0]         ALU_OPCODE,
  output logic [WIDTH-1:0]   ALU_A,
  output logic [WIDTH-1:0]   ALU_B,
  input  logic [WIDTH-1:0]   ALU_OUT,
  input  logic [3:0]         ALU_FLAGS
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  state_e           state_q;
  logic             last_q;       // requester granted most recently
  logic             busy_q;
  logic             alu_en_q;
  logic             alu_oe_q;
  logic [3:0]       alu_op_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [3:0]       rsp_flags_q;

  logic             grant_d;      // requester that would win this cycle
  logic             accept_d;     // a command is taken at the coming edge
  logic [1:0]       req_ready_d;
  logic [3:0]       op_d;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;

  // Round-robin grant and operand selection for the winning requester.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    grant_d     = 1'b0;
    accept_d    = 1'b0;
    req_ready_d = 2'b00;
    if (REQ_VALID == 2'b11) begin
      grant_d = ~last_q;
    end else begin
      grant_d = REQ_VALID[1];
    end
    // Ready is gated by reset so it always means "accepted at this edge".
    accept_d = RST_N && (state_q == IDLE) && (REQ_VALID != 2'b00);
    if (accept_d) begin
      req_ready_d = grant_d ? 2'b10 : 2'b01;
    end
    op_d = grant_d ? REQ_OPCODE[7:4]    : REQ_OPCODE[3:0];
    a_d  = grant_d ? REQ_A[WIDTH+:WIDTH] : REQ_A[0+:WIDTH];
    b_d  = grant_d ? REQ_B[WIDTH+:WIDTH] : REQ_B[0+:WIDTH];
  end

  // Sequencer FSM with all outputs registered: accept, issue, capture, respond.
  always_ff @(posedge CLK) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (!RST_N) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      busy_q      <= 1'b0;
      alu_en_q    <= 1'b0;
      alu_oe_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      // NOTE: datapath registers are reset as well because their reset value is visible on the ports.
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            alu_op_q <= op_d;
            alu_a_q  <= a_d;
            alu_b_q  <= b_d;
            rsp_id_q <= grant_d;
            last_q   <= grant_d;
            busy_q   <= 1'b1;
            alu_en_q <= 1'b1;
            alu_oe_q <= 1'b0;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          // alu registers the held operands at this edge; enable its output next.
          alu_en_q <= 1'b1;
          alu_oe_q <= 1'b1;
          state_q  <= CAPTURE;
        end
        CAPTURE: begin
          // Operands are unchanged, so the alu reload at this edge is harmless.
          rsp_data_q  <= ALU_OUT;
          rsp_flags_q <= ALU_FLAGS;
          alu_en_q    <= 1'b0;
          alu_oe_q    <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (RSP_READY) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign REQ_READY  = req_ready_d;
  assign RSP_VALID  = rsp_valid_q;
  assign RSP_ID     = rsp_id_q;
  assign RSP_DATA   = rsp_data_q;
  assign RSP_FLAGS  = rsp_flags_q;
  assign BUSY       = busy_q;
  assign ALU_EN     = alu_en_q;
  assign ALU_OE     = alu_oe_q;
  assign ALU_OPCODE = alu_op_q;
  assign ALU_A      = alu_a_q;
  assign ALU_B      = alu_b_q;

endmodule
